// File: rtl/axis_demod_frame_ctrl_pkg.sv
// axis_demod_frame_ctrl_pkg: shared defaults and frame sequencer state encoding
package axis_demod_frame_ctrl_pkg;
  localparam int DATA_W_DEF     = 48;
  localparam int SC_PER_SYM_DEF = 64;
  localparam int CNT_W_DEF      = 16;
  localparam int DRAIN_TO_DEF   = 1024;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SKIP  = 3'd1,
    S_PASS  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/axis_demod_frame_ctrl_if.sv
// axis_demod_frame_ctrl_if: AXI-Stream beat bundle (tdata/tvalid/tready/tlast)
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface axis_demod_frame_ctrl_if
  import axis_demod_frame_ctrl_pkg::*;
#(
  parameter int W = DATA_W_DEF
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_demod_frame_ctrl_sym_beat_counter.sv
// axis_demod_frame_ctrl_sym_beat_counter: beat-within-symbol and symbol counter
// Ports: aclk/aresetn, i_clr (zeroes both, wins over i_inc), i_inc (one beat),
// o_beat (0..SC_PER_SYM-1), o_sym (symbols completed), o_wrap (last beat taken now).
module axis_demod_frame_ctrl_sym_beat_counter
  import axis_demod_frame_ctrl_pkg::*;
#(
  parameter int SC_PER_SYM = SC_PER_SYM_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          i_clr,
  input  logic                          i_inc,
  output logic [$clog2(SC_PER_SYM)-1:0] o_beat,
  output logic [CNT_W-1:0]              o_sym,
  output logic                          o_wrap
);
  localparam int BW = $clog2(SC_PER_SYM);
  localparam logic [BW-1:0] LAST = BW'(SC_PER_SYM - 1);
  logic [BW-1:0]    r_beat;
  logic [CNT_W-1:0] r_sym;
  assign o_beat = r_beat;
  assign o_sym  = r_sym;
  assign o_wrap = i_inc && (r_beat == LAST);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat <= '0;
      r_sym  <= '0;
    end else if (i_clr) begin
      r_beat <= '0;
      r_sym  <= '0;
    end else if (i_inc) begin
      r_beat <= o_wrap ? '0 : r_beat + 1'b1;
      r_sym  <= r_sym + CNT_W'(o_wrap);
    end
  end
endmodule

// File: rtl/axis_demod_frame_ctrl.sv
// axis_demod_frame_ctrl: frame sequencer dropping preamble symbols ahead of the BPSK demodulator
// Ports: aclk/aresetn, start/abort control, cfg_pre_syms/cfg_pay_syms config,
// s_axis (FFT beats in), m_axis (payload beats to demod), d_axis_tvalid/tready
// (demod word monitor), demod_en, busy, done, err_sym, err_timeout, pay_sym_idx.
module axis_demod_frame_ctrl
  import axis_demod_frame_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SC_PER_SYM = SC_PER_SYM_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DRAIN_TO   = DRAIN_TO_DEF
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [3:0]              cfg_pre_syms,
  input  logic [CNT_W-1:0]        cfg_pay_syms,
  axis_demod_frame_ctrl_if.slave  s_axis,
  axis_demod_frame_ctrl_if.master m_axis,
  input  logic                    d_axis_tvalid,
  input  logic                    d_axis_tready,
  output logic                    demod_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err_sym,
  output logic                    err_timeout,
  output logic [CNT_W-1:0]        pay_sym_idx
);
  localparam int BW = $clog2(SC_PER_SYM);
  localparam int TW = $clog2(DRAIN_TO + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(SC_PER_SYM - 1);
  localparam logic [TW-1:0] TMR_MAX   = TW'(DRAIN_TO - 1);
  state_t           r_state;
  logic [3:0]       r_pre;
  logic [CNT_W-1:0] r_pay;
  logic [CNT_W-1:0] r_out_cnt;
  logic [TW-1:0]    r_tmr;
  logic             r_err_sym;
  logic             r_err_to;
  logic [BW-1:0]    w_beat;
  logic [CNT_W-1:0] w_sym;
  logic [CNT_W-1:0] w_out_nxt;
  logic [DATA_W-1:0] w_data;
  logic w_wrap, w_acc, w_pass, w_start, w_skip_end, w_dword;
  assign w_pass         = r_state == S_PASS;
  assign s_axis.tready  = (r_state == S_SKIP) || (w_pass && m_axis.tready);
  assign w_data         = w_pass ? s_axis.tdata : '0;
  assign m_axis.tdata   = w_data;
  assign m_axis.tvalid  = w_pass && s_axis.tvalid;
  assign m_axis.tlast   = w_pass && (w_beat == LAST_BEAT) && (w_sym == r_pay - 1'b1);
  assign w_acc          = s_axis.tvalid && s_axis.tready;
  assign w_start        = (r_state == S_IDLE) && start && !abort;
  assign w_skip_end     = (r_state == S_SKIP) && w_wrap && (w_sym == CNT_W'(r_pre) - 1'b1);
  // Demod words count in PASS too, so a word landing with the last beat is not lost.
  assign w_dword        = d_axis_tvalid && d_axis_tready && (w_pass || r_state == S_DRAIN);
  assign w_out_nxt      = r_out_cnt + CNT_W'(w_dword);
  assign demod_en       = w_pass || (r_state == S_DRAIN);
  assign busy           = r_state != S_IDLE;
  assign done           = r_state == S_DONE;
  assign err_sym        = r_err_sym;
  assign err_timeout    = r_err_to;
  // The shared counter holds preamble symbols while skipping; hide them.
  assign pay_sym_idx    = (r_state == S_SKIP) ? '0 : w_sym;
  axis_demod_frame_ctrl_sym_beat_counter #(
    .SC_PER_SYM(SC_PER_SYM),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .aclk   (aclk),
    .aresetn(aresetn),
    .i_clr  (w_start || w_skip_end),
    .i_inc  (w_acc),
    .o_beat (w_beat),
    .o_sym  (w_sym),
    .o_wrap (w_wrap)
  );
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_pay     <= '0;
      r_out_cnt <= '0;
      r_tmr     <= '0;
      r_err_sym <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_err_sym <= w_start ? 1'b0 : r_err_sym | (w_acc && (s_axis.tlast != (w_beat == LAST_BEAT)));
      r_out_cnt <= w_start ? '0 : w_out_nxt;
      r_tmr     <= (r_state == S_DRAIN) ? r_tmr + 1'b1 : '0;
      if (abort) r_state <= S_IDLE;
      else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_pre    <= cfg_pre_syms;
            r_pay    <= cfg_pay_syms;
            r_err_to <= 1'b0;
            r_state  <= (cfg_pay_syms == '0) ? S_DONE : (cfg_pre_syms != '0) ? S_SKIP : S_PASS;
          end
          S_SKIP:  if (w_skip_end) r_state <= S_PASS;
          S_PASS:  if (w_acc && m_axis.tlast) r_state <= S_DRAIN;
          S_DRAIN: if (w_out_nxt == r_pay) r_state <= S_DONE;
                   else if (r_tmr == TMR_MAX) begin
                     r_state  <= S_DONE;
                     r_err_to <= 1'b1;
                   end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_demod_frame_ctrl.sv
// tb_axis_demod_frame_ctrl: scoreboard bench for the demod frame sequencer
module tb_axis_demod_frame_ctrl;
  logic aclk = 1'b0, aresetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  cfg_pre = '0;
  logic [15:0] cfg_pay = '0;
  logic d_tvalid = 1'b0, d_tready = 1'b0;
  logic demod_en, busy, done, err_sym, err_timeout;
  logic [15:0] pay_sym_idx;
  int n_chk = 0, n_err = 0;
  logic [48:0] exp_q[$];
  axis_demod_frame_ctrl_if #(.W(48)) s_if ();
  axis_demod_frame_ctrl_if #(.W(48)) m_if ();
  axis_demod_frame_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_pre_syms(cfg_pre), .cfg_pay_syms(cfg_pay),
    .s_axis(s_if), .m_axis(m_if),
    .d_axis_tvalid(d_tvalid), .d_axis_tready(d_tready),
    .demod_en(demod_en), .busy(busy), .done(done), .err_sym(err_sym),
    .err_timeout(err_timeout), .pay_sym_idx(pay_sym_idx)
  );
  always #5 aclk = ~aclk;
  function automatic logic [47:0] mk(input int tag, input int i);
    return {16'(tag), 32'(i)};
  endfunction
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic push_exp(input int tag, input int from, input int to, input int last);
    for (int i = from; i <= to; i++) exp_q.push_back({mk(tag, i), i == last});
  endtask
  always @(negedge aclk) begin
    if (aresetn && m_if.tvalid && m_if.tready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got %0h_%0b expected none", m_if.tdata, m_if.tlast);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        if ({m_if.tdata, m_if.tlast} !== e) begin
          n_err++;
          $display("FAIL beat: got %0h_%0b expected %0h_%0b", m_if.tdata, m_if.tlast, e[48:1], e[0]);
        end
      end
    end
  end
  task automatic do_start(input int pre, input int pay);
    cfg_pre = 4'(pre);
    cfg_pay = 16'(pay);
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask
  task automatic send(input int pre, input int n, input int tag, input int bad, input int abort_at, input bit stall);
    int i = 0, guard = 0;
    bit acc;
    while (i < n) begin
      s_if.tvalid = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      m_if.tready = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      s_if.tdata  = mk(tag, i);
      s_if.tlast  = (bad >= 0) ? (i == bad) : (i % 64 == 63);
      abort       = (i == abort_at);
      @(negedge aclk);
      acc = s_if.tvalid && s_if.tready;
      if (acc && i == 0 && pre > 0) check("demod_en_skip", demod_en, 0);
      if (acc && i == pre * 64) check("demod_en_pass", demod_en, 1);
      @(posedge aclk); #1;
      if (acc) i++;
      if (++guard > 3000) begin
        check("send_timeout", i, n);
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    abort       = 1'b0;
  endtask
  task automatic dwords(input int n);
    d_tvalid = 1'b1;
    d_tready = 1'b1;
    repeat (n) begin @(posedge aclk); #1; end
    d_tvalid = 1'b0;
    d_tready = 1'b0;
  endtask
  initial begin
    int n;
    bit seen;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_demod_en", demod_en, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_err", {err_sym, err_timeout}, 0);
    check("rst_pay_idx", pay_sym_idx, 0);
    #20 aresetn = 1'b1;
    @(posedge aclk); #1;
    // pre=2, pay=3: 128 dropped, 192 forwarded, tlast on forwarded beat 191
    push_exp(1, 128, 319, 319);
    do_start(2, 3);
    check("t1_busy", busy, 1);
    send(2, 320, 1, -1, -1, 0);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_drain_en", demod_en, 1);
    dwords(3);
    check("t1_done", done, 1);
    check("t1_pay_idx", pay_sym_idx, 3);
    @(posedge aclk); #1;
    check("t1_done_pulse", {done, busy}, 0);
    check("t1_err", {err_sym, err_timeout}, 0);
    // pre=0, pay=1 with random stalls on both sides
    push_exp(2, 0, 63, 63);
    do_start(0, 1);
    send(0, 64, 2, -1, -1, 1);
    check("t2_sb_empty", exp_q.size(), 0);
    dwords(1);
    check("t2_done", done, 1);
    check("t2_pay_idx", pay_sym_idx, 1);
    @(posedge aclk); #1;
    // pay=0: straight to DONE, no beats taken
    s_if.tvalid = 1'b1;
    do_start(3, 0);
    check("t3_done", done, 1);
    check("t3_s_tready", s_if.tready, 0);
    check("t3_pay_idx", pay_sym_idx, 0);
    @(posedge aclk); #1;
    check("t3_idle", {done, busy}, 0);
    s_if.tvalid = 1'b0;
    // tlast on beat 62 of symbol 0: sticky err_sym, frame still ends on count
    push_exp(4, 0, 63, 63);
    do_start(0, 1);
    send(0, 64, 4, 62, -1, 0);
    check("t4_sb_empty", exp_q.size(), 0);
    dwords(1);
    check("t4_done", done, 1);
    @(posedge aclk); #1;
    check("t4_err_sym_sticky", err_sym, 1);
    // no demod words: DRAIN times out after 1024 cycles; start clears err_sym
    push_exp(5, 0, 63, 63);
    do_start(0, 1);
    check("t5_err_sym_clr", err_sym, 0);
    send(0, 64, 5, -1, -1, 0);
    n = 0;
    while (!done && n < 1100) begin @(posedge aclk); #1; n++; end
    check("t5_drain_cycles", n, 1024);
    check("t5_err_timeout", err_timeout, 1);
    @(posedge aclk); #1;
    check("t5_idle", busy, 0);
    // abort on PASS beat 40 of symbol 1
    push_exp(6, 0, 104, -1);
    do_start(0, 3);
    check("t6_err_to_clr", err_timeout, 0);
    send(0, 105, 6, -1, 104, 0);
    s_if.tvalid = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_s_tready", s_if.tready, 0);
    check("t6_pay_idx", pay_sym_idx, 1);
    check("t6_sb_empty", exp_q.size(), 0);
    seen = 0;
    repeat (4) begin seen |= done; @(posedge aclk); #1; end
    check("t6_no_done", seen, 0);
    s_if.tvalid = 1'b0;
    // async reset in the middle of SKIP
    do_start(2, 1);
    send(2, 30, 7, 5, -1, 0);
    s_if.tvalid = 1'b1;
    check("t7_err_pre", {busy, err_sym}, 2'b11);
    #2 aresetn = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_s_tready", s_if.tready, 0);
    check("t7_outs", {done, demod_en, m_if.tvalid, m_if.tlast, err_sym, err_timeout}, 0);
    check("t7_pay_idx", pay_sym_idx, 0);
    s_if.tvalid = 1'b0;
    #10 aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
